// File: rtl/mem_wb_if.sv
// Handshake buses around the writeback buffer: MEM -> WB results and WB -> register-file head.

interface mem_wb_if;
    logic        mem2wb_valid_i;
    logic        mem2wb_ready_o;
    logic        mem2wb_wb_en_i;
    logic        mem2wb_is_load_i;
    logic [2:0]  mem2wb_funct3_i;
    logic [1:0]  mem2wb_addr_lo_i;
    logic [4:0]  mem2wb_rd_i;
    logic [31:0] mem2wb_data_i;

    modport master (
        output mem2wb_valid_i, mem2wb_wb_en_i, mem2wb_is_load_i, mem2wb_funct3_i,
               mem2wb_addr_lo_i, mem2wb_rd_i, mem2wb_data_i,
        input  mem2wb_ready_o
    );
    modport slave (
        input  mem2wb_valid_i, mem2wb_wb_en_i, mem2wb_is_load_i, mem2wb_funct3_i,
               mem2wb_addr_lo_i, mem2wb_rd_i, mem2wb_data_i,
        output mem2wb_ready_o
    );
endinterface

interface wb_regs_if;
    logic        wb2regs_valid_o;
    logic        regs2wb_ready_i;
    logic        wb2regs_wb_en_o;
    logic [4:0]  wb2regs_rd_o;
    logic [31:0] wb2regs_rd_data_o;
    logic        wb2regs_misalign_o;

    modport master (
        output wb2regs_valid_o, wb2regs_wb_en_o, wb2regs_rd_o, wb2regs_rd_data_o,
               wb2regs_misalign_o,
        input  regs2wb_ready_i
    );
    modport slave (
        input  wb2regs_valid_o, wb2regs_wb_en_o, wb2regs_rd_o, wb2regs_rd_data_o,
               wb2regs_misalign_o,
        output regs2wb_ready_i
    );
endinterface

// File: rtl/mem_wb.sv
// Writeback skid buffer: 2-entry FIFO between MEMU and the register file.
// Loads are extracted/extended and alignment-checked on the way in; the youngest write is forwarded.

module mem_wb #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    mem_wb_if.slave     mem2wb,
    wb_regs_if.master   wb2regs,
    input  logic        flush_i,
    output logic        wb_fwd_en_o,
    output logic [4:0]  wb_fwd_rd_o,
    output logic [31:0] wb_fwd_data_o
);

    typedef struct packed {
        logic        wb_en;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        misalign;
    } entry_t;

    entry_t      entries [2];
    entry_t      push_entry;
    entry_t      head;
    logic        rd_ptr, wr_ptr, yng_ptr;
    logic [1:0]  count;
    logic        misalign_q;
    logic        push, pop;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic        legal, misalign;
    logic [31:0] ext_data;

    assign mem2wb.mem2wb_ready_o = (count < 2'(DEPTH));
    assign wb2regs.wb2regs_valid_o = (count != 2'd0);
    assign push = mem2wb.mem2wb_valid_i && mem2wb.mem2wb_ready_o && !flush_i;
    assign pop  = wb2regs.wb2regs_valid_o && wb2regs.regs2wb_ready_i && !flush_i;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        lane_b   = mem2wb.mem2wb_data_i[7:0];
        unique case (mem2wb.mem2wb_addr_lo_i)
            2'd1:    lane_b = mem2wb.mem2wb_data_i[15:8];
            2'd2:    lane_b = mem2wb.mem2wb_data_i[23:16];
            2'd3:    lane_b = mem2wb.mem2wb_data_i[31:24];
            default: lane_b = mem2wb.mem2wb_data_i[7:0];
        endcase
        lane_h   = mem2wb.mem2wb_addr_lo_i[1] ? mem2wb.mem2wb_data_i[31:16]
                                              : mem2wb.mem2wb_data_i[15:0];
        legal    = 1'b1;
        misalign = 1'b0;
        ext_data = mem2wb.mem2wb_data_i;
        if (mem2wb.mem2wb_is_load_i) begin
            unique case (mem2wb.mem2wb_funct3_i)
                3'b000: ext_data = {{24{lane_b[7]}}, lane_b};
                3'b100: ext_data = {24'd0, lane_b};
                3'b001: begin
                    ext_data = {{16{lane_h[15]}}, lane_h};
                    misalign = mem2wb.mem2wb_addr_lo_i[0];
                end
                3'b101: begin
                    ext_data = {16'd0, lane_h};
                    misalign = mem2wb.mem2wb_addr_lo_i[0];
                end
                3'b010:  misalign = (mem2wb.mem2wb_addr_lo_i != 2'd0);
                default: begin
                    legal    = 1'b0;
                    ext_data = '0;
                end
            endcase
        end
        push_entry.wb_en    = mem2wb.mem2wb_wb_en_i && (mem2wb.mem2wb_rd_i != 5'd0)
                              && !misalign && legal;
        push_entry.rd       = mem2wb.mem2wb_rd_i;
        push_entry.data     = misalign ? 32'd0 : ext_data;
        push_entry.misalign = misalign;
    end

    // NOTE: only two entries, so storage is reset along with the control state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) entries[i] <= '0;
            rd_ptr     <= 1'b0;
            wr_ptr     <= 1'b0;
            count      <= 2'd0;
            misalign_q <= 1'b0;
        end else if (flush_i) begin
            rd_ptr     <= 1'b0;
            wr_ptr     <= 1'b0;
            count      <= 2'd0;
            misalign_q <= 1'b0;
        end else begin
            if (push) begin
                entries[wr_ptr] <= push_entry;
                wr_ptr          <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            unique case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
            misalign_q <= pop && entries[rd_ptr].misalign;
        end
    end

    always_comb begin
        head = '0;
        if (wb2regs.wb2regs_valid_o) head = entries[rd_ptr];
    end

    assign wb2regs.wb2regs_wb_en_o    = wb2regs.wb2regs_valid_o && head.wb_en;
    assign wb2regs.wb2regs_rd_o       = head.rd;
    assign wb2regs.wb2regs_rd_data_o  = head.data;
    assign wb2regs.wb2regs_misalign_o = misalign_q;

    // Youngest pending write wins; the older entry only matters when both are occupied.
    assign yng_ptr = wr_ptr - 1'b1;

    always_comb begin
        wb_fwd_en_o   = 1'b0;
        wb_fwd_rd_o   = '0;
        wb_fwd_data_o = '0;
        if (count != 2'd0 && entries[yng_ptr].wb_en) begin
            wb_fwd_en_o   = 1'b1;
            wb_fwd_rd_o   = entries[yng_ptr].rd;
            wb_fwd_data_o = entries[yng_ptr].data;
        end else if (count == 2'd2 && entries[rd_ptr].wb_en) begin
            wb_fwd_en_o   = 1'b1;
            wb_fwd_rd_o   = entries[rd_ptr].rd;
            wb_fwd_data_o = entries[rd_ptr].data;
        end
    end

endmodule

// File: doc/mem_wb.md
# mem_wb

Writeback stage buffer between MEMU and the register file. It accepts MEM-stage results through a valid/ready handshake and holds them in a 2-entry FIFO (skid buffer). At enqueue it extracts, sign- or zero-extends and checks alignment of load data (LB/LH/LW/LBU/LHU). It presents the oldest entry to regs with its own handshake and exports the youngest pending write for operand forwarding.

## Interface
Parameters:
- DEPTH, 2: entry count; only 2 is supported.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- mem2wb_valid_i  in  1  MEM presents a result this cycle.
- mem2wb_ready_o  out  1  buffer can accept; equals (count < 2).
- mem2wb_wb_en_i  in  1  result writes a register.
- mem2wb_is_load_i  in  1  result is a load; data_i is the raw aligned word.
- mem2wb_funct3_i  in  3  RISC-V funct3 of the instruction.
- mem2wb_addr_lo_i  in  2  effective address bits [1:0].
- mem2wb_rd_i  in  5  destination register.
- mem2wb_data_i  in  32  raw memory word (load) or result (non-load).
- flush_i  in  1  synchronous flush of all entries.
- wb2regs_valid_o  out  1  head entry present.
- regs2wb_ready_i  in  1  regs consumes the head this cycle.
- wb2regs_wb_en_o  out  1  head write enable, qualified as below.
- wb2regs_rd_o  out  5  head rd.
- wb2regs_rd_data_o  out  32  head data, already extended.
- wb2regs_misalign_o  out  1  high for one cycle when a misaligned-load entry is popped.
- wb_fwd_en_o, wb_fwd_rd_o (5), wb_fwd_data_o (32)  out  forwarding from the youngest valid writing entry.

## Operation
- Push: (mem2wb_valid_i && mem2wb_ready_o && !flush_i). Pop: (wb2regs_valid_o && regs2wb_ready_i && !flush_i).
- Storage: two entries, rd_ptr/wr_ptr (1 bit each) and count (0..2). Pointers wrap modulo 2.
- Entry fields: wb_en, rd, data, misalign. Computed at push time:
  - Non-load: data = data_i; misalign = 0.
  - LB (000): byte lane addr_lo, sign-extended. LBU (100): same lane, zero-extended.
  - LH (001): half at addr_lo[1], sign-extended. LHU (101): zero-extended.
  - LW (010): data_i.
  - misalign = 1 for LH/LHU with addr_lo[0]=1, and for LW with addr_lo≠0. A misaligned entry stores data 0.
  - Load with funct3 011/110/111: wb_en stored 0, data 0, misalign 0.
  - Stored wb_en = wb_en_i && rd≠0 && !misalign && legal.
- Head outputs:
  - wb2regs_valid_o = count≠0.
  - wb2regs_wb_en_o = valid && head.wb_en.
  - rd_o and rd_data_o show the head fields and are 0 when empty.
- wb2regs_misalign_o is registered. It is set on the cycle after a pop of a misaligned entry and lasts 1 cycle.
- Forwarding selects the youngest entry (wr_ptr-1) when count≥1 and that entry's wb_en=1. Otherwise it selects the other valid entry if it has wb_en=1. If neither qualifies, fwd_en=0 and rd/data are 0.
- flush_i clears count and pointers and suppresses push, pop and misalign pulse. It has priority over everything except reset.

## Timing
- Reset (async assert, sync release): count=0, pointers=0, all entries cleared. Outputs: ready_o=1; valid_o=0; wb_en_o=0; rd_o=0; rd_data_o=0; misalign_o=0; fwd_*=0.
- Latency: data pushed in cycle N appears at the head and on forwarding in cycle N+1 when the buffer was empty.
- mem2wb_ready_o depends only on registered count, with no combinational path from regs2wb_ready_i.
- count=1 with push and pop in the same cycle: count stays 1 and the new entry becomes head.
- count=2: ready_o=0, so a pop frees a slot that can be used the next cycle.
- count=0 with push: no pop that cycle.
- Throughput: 1 per cycle while regs2wb_ready_i=1.
- Flush together with push or pop: both are dropped and count=0 next cycle.
- Reset mid-operation: all state is lost immediately and no partial write occurs.

## Test plan
- Reset: hold rst_n=0 with valid_i=1 → ready_o=1, valid_o=0, all outputs 0. Release, push one entry → visible exactly 1 cycle later.
- Load extension:
  - data_i=0x80FF7F01 with LB at addr_lo=3 → rd_data 0xFFFFFF80.
  - LBU at addr_lo=1 → 0x0000007F.
  - LH at addr_lo=2 → 0xFFFF80FF.
  - LHU at addr_lo=0 → 0x00007F01.
  - LW → 0x80FF7F01.
- Misalign: LW at addr_lo=2 with rd=5 → wb_en_o=0 at head, misalign_o=1 on the cycle after the pop. LH at addr_lo=1 → same.
- Backpressure: regs2wb_ready_i=0 with 3 pushes attempted → ready_o drops after 2 and the 3rd is held. Release → pops in order.
- Pointer wrap and x0: streaming through the FIFO → count stays 1 and pointers wrap. Entry with rd=0 → wb_en_o=0 and fwd_en=0.
- Forwarding and flush:
  - Two pending writes to rd=7, data 0x11 then 0x22 → fwd_data=0x22.
  - flush_i with a simultaneous push → next cycle valid_o=0, count=0, fwd_en=0.
